ram_burst_controller: RTL and testbench
=======================================

# ram_burst_controller

Parametrised successor to the single-word RAM controller: moves whole cache lines of LINE_WORDS words between the set-associative cache controller and a single-port synchronous RAM with configurable read latency. Supports line fill, line writeback and a combined evict-then-fill in one request, with read addresses issued back-to-back (pipelined) rather than one word per handshake. Sits between the cache controller and the external RAM pins inside the memory-hierarchy top.

## Interface
- ADDR_W, 20, RAM word-address width
- DATA_W, 32, RAM word width; multiple of 8
- LINE_WORDS, 4, words per cache line; power of two, >= 2
- RD_LAT, 1, cycles from address presented to read data valid; 1..4
- LINE_AW (derived), ADDR_W - log2(LINE_WORDS), line-address width

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; req accepted on clk edge with req_valid && req_ready
- req_op  in  2  00 fill, 01 writeback, 10 evict-then-fill, 11 no-op
- req_fill_addr  in  LINE_AW  line address to read
- req_wb_addr  in  LINE_AW  line address to write
- req_wb_line  in  LINE_WORDS*DATA_W  line to write, word 0 in LSBs
- resp_valid  out  1  one-cycle completion pulse
- resp_line  out  LINE_WORDS*DATA_W  filled line, word 0 in LSBs
- ram_addr  out  ADDR_W  RAM word address
- ram_data_w  out  DATA_W  RAM write data
- ram_data_r  in  DATA_W  RAM read data
- WE  out  1  RAM write enable
- BE  out  DATA_W/8  RAM byte enables

## Operation
- States: IDLE, WB, RD, DRAIN, RESP.
- IDLE: req_ready = 1 (0 while rst low). On acceptance, latch op, both addresses and req_wb_line; go WB for ops 01/10, RD for op 00, RESP for op 11.
- WB: one word per cycle, word counter i = 0..LINE_WORDS-1; ram_addr = {wb_addr, i}, ram_data_w = word i, WE = 1, BE = all ones. After last word: op 01 -> RESP, op 10 -> RD.
- RD: one address per cycle, ram_addr = {fill_addr, k}, WE = 0, BE = 0. A RD_LAT-deep valid/index shift register tags each issued address; tagged data is written into word slot of resp_line on the cycle it is valid. After last address -> DRAIN.
- DRAIN: WE = 0; wait until last tagged word captured -> RESP.
- RESP: resp_valid = 1 for exactly one cycle -> IDLE. resp_line stable from RESP until next fill captures; writeback-only and no-op leave resp_line unchanged.
- Outside WB: WE = 0, BE = 0, ram_data_w = 0. In IDLE/RESP ram_addr = 0.
- Word counters wrap at LINE_WORDS; no carry into line address.
- req_valid while req_ready = 0 is ignored; no queueing.

## Timing
- Cycle n = n-th cycle after the acceptance edge.
- Fill (00): addresses in cycles 1..LW; word k data on ram_data_r in cycle 1+k+RD_LAT-1+... i.e. address in cycle c -> data sampled at end of cycle c+RD_LAT-1+1 = cycle c+RD_LAT; resp_valid in cycle LW+RD_LAT+1.
- Writeback (01): WE high cycles 1..LW; resp_valid in cycle LW+1.
- Evict-then-fill (10): writes cycles 1..LW, read addresses cycles LW+1..2LW; resp_valid in cycle 2LW+RD_LAT+1. No idle cycle between last write and first read.
- No-op (11): resp_valid in cycle 1.
- req_ready returns to 1 the cycle after resp_valid; back-to-back requests separated by exactly one RESP cycle.
- Reset (rst low, any time): state IDLE, counters and shift register cleared, resp_valid 0, resp_line 0, ram_addr 0, ram_data_w 0, WE 0, BE 0, req_ready 0. Mid-operation reset aborts without resp_valid; in-flight read data discarded; a partially written RAM line is undefined.

## Test plan
- Reset: drive rst low mid-writeback (cycle 2) -> WE/BE/ram_addr/resp_valid drop to 0 immediately, no resp_valid after release, req_ready 1 first cycle after rst high.
- Fill, LW=4, RD_LAT=1, fill_addr 0x12345 (ADDR_W=20): ram_addr 0x48D14..0x48D17 in cycles 1..4, RAM returns 0xA0..0xA3 -> resp_valid cycle 6, resp_line = {0xA3,0xA2,0xA1,0xA0}.
- Writeback, wb_addr 0x00010, line {0x44,0x33,0x22,0x11}: WE=1, BE=0xF cycles 1..4 at 0x00040..0x00043 with 0x11..0x44 -> resp_valid cycle 5.
- Evict-then-fill, RD_LAT=3, wb_addr 0x1, fill_addr 0x2: writes 0x4..0x7 cycles 1..4, reads 0x8..0xB cycles 5..8 -> resp_valid cycle 12, resp_line equals RAM model contents.
- Handshake: req_valid held high throughout two fills -> second accepted only in cycle after first resp_valid; req_valid pulsed while busy -> ignored, exactly one resp_valid.
- No-op and parameter sweep: op 11 -> resp_valid cycle 1, no RAM activity; repeat fill for LW in {2,8}, RD_LAT in {1..4} against scoreboard.

Source files
------------

// File: rtl/ram_burst_controller.sv
// Purpose: moves whole cache lines between the cache controller and a single-port
//   synchronous RAM: line fill, line writeback, or evict-then-fill in one request.
// Latency: fill LW+RD_LAT+1, writeback LW+1, evict-then-fill 2*LW+RD_LAT+1, no-op 1 cycle.
// Backpressure: req_ready only in IDLE; requests seen while busy are dropped, not queued.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_*               request handshake, op code, fill/writeback line addresses, line to write
//   resp_valid/line     one-cycle completion pulse and the last filled line (word 0 in LSBs)
//   ram_*, WE, BE       RAM word address, write data, read data, write enable, byte enables
module ram_burst_controller #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int RD_LAT     = 1,
  localparam int WIDX      = $clog2(LINE_WORDS),
  localparam int LINE_AW   = ADDR_W - WIDX
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [LINE_AW-1:0]           req_fill_addr,
  input  logic [LINE_AW-1:0]           req_wb_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] req_wb_line,
  output logic                         resp_valid,
  output logic [LINE_WORDS*DATA_W-1:0] resp_line,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic [DATA_W-1:0]            ram_data_w,
  input  logic [DATA_W-1:0]            ram_data_r,
  output logic                         WE,
  output logic [DATA_W/8-1:0]          BE
);

  typedef enum logic [2:0] {IDLE, WB, RD, DRAIN, RESP} state_t;

  localparam logic [1:0]      OP_FILL  = 2'b00;
  localparam logic [1:0]      OP_EVICT = 2'b10;
  localparam logic [1:0]      OP_NOP   = 2'b11;
  localparam logic [WIDX-1:0] LAST     = WIDX'(LINE_WORDS - 1);
  localparam logic [WIDX-1:0] ZERO     = {WIDX{1'b0}};

  state_t                         state;
  logic [1:0]                     op_q;
  logic [LINE_AW-1:0]             fill_q;
  logic [LINE_AW-1:0]             wb_q;
  logic [LINE_WORDS*DATA_W-1:0]   line_q;
  logic [WIDX-1:0]                cnt;      // index of the word on the RAM bus this cycle
  logic [WIDX-1:0]                cnt_nxt;
  logic                           sr_vld [RD_LAT];
  logic [WIDX-1:0]                sr_idx [RD_LAT];
  logic                           capture_last;

  // Ready is gated by reset so nothing is accepted while rst is low.
  assign req_ready    = rst && (state == IDLE);
  assign cnt_nxt      = cnt + WIDX'(1);
  assign capture_last = sr_vld[RD_LAT-1] && (sr_idx[RD_LAT-1] == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      fill_q     <= '0;
      wb_q       <= '0;
      line_q     <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_line  <= '0;
      ram_addr   <= '0;
      ram_data_w <= '0;
      WE         <= 1'b0;
      BE         <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        sr_vld[i] <= 1'b0;
        sr_idx[i] <= '0;
      end
    end else begin
      // Every read address is tagged with its word slot; the tag reaches the
      // last stage exactly when the RAM presents that word's data.
      sr_vld[0] <= (state == RD);
      sr_idx[0] <= cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        sr_vld[i] <= sr_vld[i-1];
        sr_idx[i] <= sr_idx[i-1];
      end
      if (sr_vld[RD_LAT-1]) begin
        resp_line[sr_idx[RD_LAT-1]*DATA_W +: DATA_W] <= ram_data_r;
      end

      resp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            fill_q <= req_fill_addr;
            wb_q   <= req_wb_addr;
            line_q <= req_wb_line;
            cnt    <= '0;
            case (req_op)
              OP_FILL: begin
                state    <= RD;
                ram_addr <= {req_fill_addr, ZERO};
              end
              OP_NOP: begin
                state      <= RESP;
                resp_valid <= 1'b1;
              end
              default: begin
                // Word 0 goes out in the first cycle after acceptance.
                state      <= WB;
                ram_addr   <= {req_wb_addr, ZERO};
                ram_data_w <= req_wb_line[DATA_W-1:0];
                WE         <= 1'b1;
                BE         <= '1;
              end
            endcase
          end
        end

        WB: begin
          if (cnt == LAST) begin
            WE         <= 1'b0;
            BE         <= '0;
            ram_data_w <= '0;
            cnt        <= '0;
            if (op_q == OP_EVICT) begin
              // First read address follows the last write with no gap.
              state    <= RD;
              ram_addr <= {fill_q, ZERO};
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              ram_addr   <= '0;
            end
          end else begin
            cnt        <= cnt_nxt;
            ram_addr   <= {wb_q, cnt_nxt};
            ram_data_w <= line_q[cnt_nxt*DATA_W +: DATA_W];
          end
        end

        RD: begin
          if (cnt == LAST) begin
            state    <= DRAIN;
            ram_addr <= '0;
            cnt      <= '0;
          end else begin
            cnt      <= cnt_nxt;
            ram_addr <= {fill_q, cnt_nxt};
          end
        end

        DRAIN: begin
          // Data returns in issue order, so the last slot marks completion.
          if (capture_last) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_controller.sv
module tb_ram_burst_controller;

  localparam int NC = 6;  // configurations: (LW,RD_LAT) = (4,1) (4,3) (2,1) (2,2) (8,3) (8,4)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]             req_valid;
  logic [NC-1:0][1:0]        req_op;
  logic [NC-1:0][19:0]       req_fill;
  logic [NC-1:0][19:0]       req_wb;
  logic [NC-1:0][255:0]      req_line;
  logic [NC-1:0]             rdy;
  logic [NC-1:0]             rv;
  logic [NC-1:0]             we;
  logic [NC-1:0][3:0]        be;
  logic [NC-1:0][19:0]       addr;
  logic [NC-1:0][31:0]       wd;
  logic [NC-1:0][255:0]      rline;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int cfg_lw(int g);
    case (g)
      0, 1:    return 4;
      2, 3:    return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_rl(int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 1;
      3:       return 2;
      4:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_w(int g);
    return $clog2(cfg_lw(g));
  endfunction

  // Initial RAM contents, indexed by the low 8 address bits.
  function automatic logic [31:0] ram_init(int g, int a);
    if (g == 0 && a >= 'h14 && a <= 'h17) return 32'(32'hA0 + a - 'h14);
    return {8'(g), 8'h5A, 16'(a)};
  endfunction

  for (genvar g = 0; g < NC; g++) begin : gen_cfg
    localparam int LW = cfg_lw(g);
    localparam int RL = cfg_rl(g);
    localparam int AW = 20 - $clog2(LW);

    logic [LW*32-1:0] rl_g;
    logic [31:0]      rdata;
    logic [31:0]      mem [256];
    logic [31:0]      pipe [RL];

    ram_burst_controller #(
      .ADDR_W(20), .DATA_W(32), .LINE_WORDS(LW), .RD_LAT(RL)
    ) u_dut (
      .clk(clk),
      .rst(rst_n),
      .req_valid(req_valid[g]),
      .req_ready(rdy[g]),
      .req_op(req_op[g]),
      .req_fill_addr(req_fill[g][AW-1:0]),
      .req_wb_addr(req_wb[g][AW-1:0]),
      .req_wb_line(req_line[g][LW*32-1:0]),
      .resp_valid(rv[g]),
      .resp_line(rl_g),
      .ram_addr(addr[g]),
      .ram_data_w(wd[g]),
      .ram_data_r(rdata),
      .WE(we[g]),
      .BE(be[g])
    );

    assign rline[g] = 256'(rl_g);

    initial begin
      for (int i = 0; i < 256; i++) mem[i] <= ram_init(g, i);
    end

    // Synchronous RAM with RL cycles from address to data.
    always @(posedge clk) begin
      pipe[0] <= mem[addr[g][7:0]];
      if (we[g]) mem[addr[g][7:0]] <= wd[g];
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign rdata = pipe[RL-1];
  end

  // Presents one request in cycle 0; returns at the falling edge of cycle 1.
  task automatic drive_req(input int g, input logic [1:0] op, input logic [19:0] fa,
                           input logic [19:0] wa, input logic [255:0] ln);
    @(negedge clk);
    req_valid[g] = 1'b1;
    req_op[g]    = op;
    req_fill[g]  = fa;
    req_wb[g]    = wa;
    req_line[g]  = ln;
    @(posedge clk);
    @(negedge clk);
    req_valid[g] = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({rdy[0], rv[0], we[0], be[0], addr[0], wd[0]} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b we=%b be=%h addr=%h wd=%h, want all 0",
               rdy[0], rv[0], we[0], be[0], addr[0], wd[0]);
    end
    n_cmp++;
    if (rline[0] !== '0) begin
      n_bad++;
      $display("FAIL reset_resp_line: got %h want 0", rline[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rdy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_release: got %b want 1", rdy[0]);
    end
    // Abort a writeback in its second write cycle.
    drive_req(0, 2'b01, 20'h0, 20'h00010, 256'h44_00000033_00000022_00000011);
    @(negedge clk);
    n_cmp++;
    if (we[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pre_we: got %b want 1", we[0]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({we[0], be[0], addr[0], rv[0], rdy[0]} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_wb: got we=%b be=%h addr=%h rv=%b rdy=%b, want all 0",
               we[0], be[0], addr[0], rv[0], rdy[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rdy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_ready: got %b want 1", rdy[0]);
    end
    begin
      int act = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (rv[0] === 1'b1 || we[0] === 1'b1) act++;
      end
      n_cmp++;
      if (act !== 0) begin
        n_bad++;
        $display("FAIL reset_no_resp: got %0d active cycles want 0", act);
      end
    end
  endtask

  task automatic test_fill;
    n_cmp++;
    if (rdy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_ready: got %b want 1", rdy[0]);
    end
    drive_req(0, 2'b00, 20'h12345, 20'h0, 256'h0);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) begin
        n_cmp++;
        if (addr[0] !== 20'(20'h48D14 + c - 1) || we[0] !== 1'b0 || be[0] !== 4'h0) begin
          n_bad++;
          $display("FAIL fill_addr c%0d: got addr=%h we=%b be=%h want addr=%h we=0 be=0",
                   c, addr[0], we[0], be[0], 20'(20'h48D14 + c - 1));
        end
      end
      n_cmp++;
      if (rv[0] !== (c == 6)) begin
        n_bad++;
        $display("FAIL fill_resp c%0d: got %b want %b", c, rv[0], c == 6);
      end
      if (c == 6) begin
        n_cmp++;
        if (rline[0] !== 256'h000000A3_000000A2_000000A1_000000A0 || addr[0] !== 20'h0) begin
          n_bad++;
          $display("FAIL fill_line: got line=%h addr=%h want line=A3A2A1A0 addr=0",
                   rline[0], addr[0]);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (rdy[0] !== 1'b1) begin
          n_bad++;
          $display("FAIL fill_ready_after: got %b want 1", rdy[0]);
        end
      end
      if (c < 7) @(negedge clk);
    end
  endtask

  task automatic test_writeback;
    drive_req(0, 2'b01, 20'h0, 20'h00010, 256'h44_00000033_00000022_00000011);
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) begin
        n_cmp++;
        if (addr[0] !== 20'(20'h40 + c - 1) || we[0] !== 1'b1 || be[0] !== 4'hF ||
            wd[0] !== 32'(32'h11 * c)) begin
          n_bad++;
          $display("FAIL wb_word c%0d: got addr=%h we=%b be=%h wd=%h want addr=%h we=1 be=f wd=%h",
                   c, addr[0], we[0], be[0], wd[0], 20'(20'h40 + c - 1), 32'(32'h11 * c));
        end
      end
      n_cmp++;
      if (rv[0] !== (c == 5)) begin
        n_bad++;
        $display("FAIL wb_resp c%0d: got %b want %b", c, rv[0], c == 5);
      end
      if (c == 5) begin
        n_cmp++;
        if (we[0] !== 1'b0 || wd[0] !== 32'h0 ||
            rline[0] !== 256'h000000A3_000000A2_000000A1_000000A0) begin
          n_bad++;
          $display("FAIL wb_after: got we=%b wd=%h line=%h want we=0 wd=0 line unchanged",
                   we[0], wd[0], rline[0]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_evict;
    logic [255:0] exp_line;
    exp_line = '0;
    for (int k = 0; k < 4; k++) exp_line[k*32 +: 32] = ram_init(1, 8 + k);
    n_cmp++;
    if (rdy[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL evict_ready: got %b want 1", rdy[1]);
    end
    drive_req(1, 2'b10, 20'h2, 20'h1, 256'hD3_000000D2_000000D1_000000D0);
    for (int c = 1; c <= 13; c++) begin
      if (c <= 4) begin
        n_cmp++;
        if (addr[1] !== 20'(4 + c - 1) || we[1] !== 1'b1 || wd[1] !== 32'(32'hD0 + c - 1)) begin
          n_bad++;
          $display("FAIL evict_write c%0d: got addr=%h we=%b wd=%h want addr=%h we=1 wd=%h",
                   c, addr[1], we[1], wd[1], 20'(4 + c - 1), 32'(32'hD0 + c - 1));
        end
      end else if (c <= 8) begin
        n_cmp++;
        if (addr[1] !== 20'(8 + c - 5) || we[1] !== 1'b0 || be[1] !== 4'h0) begin
          n_bad++;
          $display("FAIL evict_read c%0d: got addr=%h we=%b be=%h want addr=%h we=0 be=0",
                   c, addr[1], we[1], be[1], 20'(8 + c - 5));
        end
      end
      n_cmp++;
      if (rv[1] !== (c == 12)) begin
        n_bad++;
        $display("FAIL evict_resp c%0d: got %b want %b", c, rv[1], c == 12);
      end
      if (c == 12) begin
        n_cmp++;
        if (rline[1] !== exp_line) begin
          n_bad++;
          $display("FAIL evict_line: got %h want %h", rline[1], exp_line);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_handshake;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_op[0]    = 2'b00;
    req_fill[0]  = 20'h20;
    for (int c = 0; c <= 14; c++) begin
      n_cmp++;
      if (rdy[0] !== (c == 0 || c == 7 || c == 14)) begin
        n_bad++;
        $display("FAIL hs_ready c%0d: got %b want %b", c, rdy[0], c == 0 || c == 7 || c == 14);
      end
      n_cmp++;
      if (rv[0] !== (c == 6 || c == 13)) begin
        n_bad++;
        $display("FAIL hs_resp c%0d: got %b want %b", c, rv[0], c == 6 || c == 13);
      end
      if (c == 8) begin
        n_cmp++;
        if (addr[0] !== 20'h80) begin
          n_bad++;
          $display("FAIL hs_second_addr: got %h want 00080", addr[0]);
        end
        req_valid[0] = 1'b0;
      end
      @(negedge clk);
    end
    // A request pulsed during a writeback must be dropped.
    drive_req(0, 2'b01, 20'h0, 20'h00030, 256'h1);
    begin
      int n_resp = 0;
      int n_rd   = 0;
      for (int c = 1; c <= 12; c++) begin
        if (rv[0] === 1'b1) n_resp++;
        if (we[0] === 1'b0 && addr[0] !== 20'h0) n_rd++;
        if (c == 2) begin
          req_valid[0] = 1'b1;
          req_op[0]    = 2'b00;
        end
        if (c == 3) req_valid[0] = 1'b0;
        @(negedge clk);
      end
      n_cmp++;
      if (n_resp !== 1) begin
        n_bad++;
        $display("FAIL hs_pulse_resp: got %0d pulses want 1", n_resp);
      end
      n_cmp++;
      if (n_rd !== 0) begin
        n_bad++;
        $display("FAIL hs_pulse_reads: got %0d read cycles want 0", n_rd);
      end
    end
  endtask

  task automatic test_noop;
    logic [255:0] exp_line;
    exp_line = '0;
    for (int k = 0; k < 4; k++) exp_line[k*32 +: 32] = ram_init(0, 'h80 + k);
    drive_req(0, 2'b11, 20'h7, 20'h9, 256'hFF);
    n_cmp++;
    if (rv[0] !== 1'b1 || we[0] !== 1'b0 || addr[0] !== 20'h0) begin
      n_bad++;
      $display("FAIL noop_c1: got rv=%b we=%b addr=%h want rv=1 we=0 addr=0", rv[0], we[0], addr[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (rv[0] !== 1'b0 || rdy[0] !== 1'b1 || we[0] !== 1'b0 || rline[0] !== exp_line) begin
      n_bad++;
      $display("FAIL noop_c2: got rv=%b rdy=%b we=%b line=%h want rv=0 rdy=1 we=0 line=%h",
               rv[0], rdy[0], we[0], rline[0], exp_line);
    end
  endtask

  task automatic test_sweep;
    for (int g = 2; g < NC; g++) begin
      int lw = cfg_lw(g);
      int rl = cfg_rl(g);
      int w  = cfg_w(g);
      logic [255:0] exp_line;
      exp_line = '0;
      for (int k = 0; k < lw; k++) exp_line[k*32 +: 32] = ram_init(g, ((32'h15 << w) + k) & 255);
      drive_req(g, 2'b00, 20'h15, 20'h0, 256'h0);
      for (int c = 1; c <= lw + rl + 2; c++) begin
        if (c <= lw) begin
          n_cmp++;
          if (addr[g] !== 20'((32'h15 << w) + c - 1)) begin
            n_bad++;
            $display("FAIL sweep%0d_addr c%0d: got %h want %h", g, c, addr[g],
                     20'((32'h15 << w) + c - 1));
          end
        end
        n_cmp++;
        if (rv[g] !== (c == lw + rl + 1)) begin
          n_bad++;
          $display("FAIL sweep%0d_resp c%0d: got %b want %b", g, c, rv[g], c == lw + rl + 1);
        end
        if (c == lw + rl + 1) begin
          n_cmp++;
          if (rline[g] !== exp_line) begin
            n_bad++;
            $display("FAIL sweep%0d_line: got %h want %h", g, rline[g], exp_line);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    req_valid = '0;
    req_op    = '0;
    req_fill  = '0;
    req_wb    = '0;
    req_line  = '0;
    test_reset;
    test_fill;
    test_writeback;
    test_evict;
    test_handshake;
    test_noop;
    test_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
